// File: rtl/id_ex_register_pkg.sv
// id_ex_register_pkg: shared widths, ALU class encodings and bubble constants for the ID/EX stage
package id_ex_register_pkg;
  localparam int NBITS_D = 32;
  localparam int RBITS_D = 5;
  localparam int ANBITS_D = 6;
  localparam int NBITSCONTROL_D = 2;
  localparam int BCBITS_D = 16;
  localparam logic [RBITS_D-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_e;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;
  localparam ctrl_t BUBBLE_CTRL = '0;
  localparam aluop_e BUBBLE_ALUOP = ALU_ADD;
endpackage

// File: rtl/id_ex_register_hazard_detect.sv
// id_ex_register_hazard_detect: combinational load-use hazard between the load in EX and the instruction in ID
module id_ex_register_hazard_detect
  import id_ex_register_pkg::*;
#(
  parameter int RBITS = RBITS_D
) (
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [RBITS-1:0] i_ex_rt,
  input  logic             i_id_valid,
  input  logic [RBITS-1:0] i_id_rs,
  input  logic [RBITS-1:0] i_id_rt,
  input  logic             i_stall,
  output logic             o_haz,
  output logic             o_stall_ifid
);
  assign o_haz = i_ex_valid & i_ex_mem_read & (i_ex_rt != RBITS'(REG_ZERO)) & i_id_valid &
                 ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
  assign o_stall_ifid = o_haz & ~i_stall;
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with bubble insertion on flush/load-use and a saturating bubble counter
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int NBITS        = NBITS_D,
  parameter int RBITS        = RBITS_D,
  parameter int ANBITS       = ANBITS_D,
  parameter int NBITSCONTROL = NBITSCONTROL_D,
  parameter int BCBITS       = BCBITS_D
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_Stall,
  input  logic                    i_Flush,
  input  logic                    i_Valid,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic                    i_RegWrite,
  input  logic                    i_MemRead,
  input  logic                    i_MemWrite,
  input  logic                    i_MemtoReg,
  input  logic                    i_ALUSrc,
  input  logic                    i_RegDst,
  input  logic [RBITS-1:0]        i_Rs,
  input  logic [RBITS-1:0]        i_Rt,
  input  logic [RBITS-1:0]        i_Rd,
  input  logic [RBITS-1:0]        i_Shamt,
  input  logic [NBITS-1:0]        i_Data1,
  input  logic [NBITS-1:0]        i_Data2,
  input  logic [NBITS-1:0]        i_Imm,
  input  logic [NBITS-1:0]        i_PC4,
  output logic                    o_Valid,
  output logic [ANBITS-1:0]       o_Funct,
  output logic [ANBITS-1:0]       o_Opcode,
  output logic [NBITSCONTROL-1:0] o_ALUOp,
  output logic                    o_RegWrite,
  output logic                    o_MemRead,
  output logic                    o_MemWrite,
  output logic                    o_MemtoReg,
  output logic                    o_ALUSrc,
  output logic                    o_RegDst,
  output logic [RBITS-1:0]        o_Rs,
  output logic [RBITS-1:0]        o_Rt,
  output logic [RBITS-1:0]        o_Rd,
  output logic [RBITS-1:0]        o_Shamt,
  output logic [NBITS-1:0]        o_Data1,
  output logic [NBITS-1:0]        o_Data2,
  output logic [NBITS-1:0]        o_Imm,
  output logic [NBITS-1:0]        o_PC4,
  output logic                    o_Stall_IFID,
  output logic [BCBITS-1:0]       o_BubbleCount
);
  typedef struct packed {
    logic                    valid;
    logic [ANBITS-1:0]       funct;
    logic [ANBITS-1:0]       opcode;
    logic [NBITSCONTROL-1:0] alu_op;
    ctrl_t                   ctrl;
    logic [RBITS-1:0]        rs;
    logic [RBITS-1:0]        rt;
    logic [RBITS-1:0]        rd;
    logic [RBITS-1:0]        shamt;
    logic [NBITS-1:0]        data1;
    logic [NBITS-1:0]        data2;
    logic [NBITS-1:0]        imm;
    logic [NBITS-1:0]        pc4;
  } stage_t;
  stage_t            r_stage;
  stage_t            w_in;
  stage_t            w_bubble_val;
  logic [BCBITS-1:0] r_count;
  logic              w_haz;
  logic              w_bubble;
  id_ex_register_hazard_detect #(.RBITS(RBITS)) u_hazard (
    .i_ex_valid   (r_stage.valid),
    .i_ex_mem_read(r_stage.ctrl.mem_read),
    .i_ex_rt      (r_stage.rt),
    .i_id_valid   (i_Valid),
    .i_id_rs      (i_Rs),
    .i_id_rt      (i_Rt),
    .i_stall      (i_Stall),
    .o_haz        (w_haz),
    .o_stall_ifid (o_Stall_IFID)
  );
  assign w_in = '{valid: i_Valid, funct: i_Funct, opcode: i_Opcode, alu_op: i_ALUOp,
                  ctrl: '{reg_write: i_RegWrite, mem_read: i_MemRead, mem_write: i_MemWrite,
                          mem_to_reg: i_MemtoReg, alu_src: i_ALUSrc, reg_dst: i_RegDst},
                  rs: i_Rs, rt: i_Rt, rd: i_Rd, shamt: i_Shamt,
                  data1: i_Data1, data2: i_Data2, imm: i_Imm, pc4: i_PC4};
  always_comb begin
    w_bubble_val        = '0;
    w_bubble_val.alu_op = NBITSCONTROL'(BUBBLE_ALUOP);
    w_bubble_val.ctrl   = BUBBLE_CTRL;
  end
  // A flush coinciding with a hazard still yields a single bubble and a single count.
  assign w_bubble = i_Flush | w_haz;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stage <= '0;
      r_count <= '0;
    end else if (!i_Stall) begin
      r_stage <= w_bubble ? w_bubble_val : w_in;
      if (w_bubble && r_count != '1) r_count <= r_count + BCBITS'(1);
    end
  end
  assign o_Valid       = r_stage.valid;
  assign o_Funct       = r_stage.funct;
  assign o_Opcode      = r_stage.opcode;
  assign o_ALUOp       = r_stage.alu_op;
  assign o_RegWrite    = r_stage.ctrl.reg_write;
  assign o_MemRead     = r_stage.ctrl.mem_read;
  assign o_MemWrite    = r_stage.ctrl.mem_write;
  assign o_MemtoReg    = r_stage.ctrl.mem_to_reg;
  assign o_ALUSrc      = r_stage.ctrl.alu_src;
  assign o_RegDst      = r_stage.ctrl.reg_dst;
  assign o_Rs          = r_stage.rs;
  assign o_Rt          = r_stage.rt;
  assign o_Rd          = r_stage.rd;
  assign o_Shamt       = r_stage.shamt;
  assign o_Data1       = r_stage.data1;
  assign o_Data2       = r_stage.data2;
  assign o_Imm         = r_stage.imm;
  assign o_PC4         = r_stage.pc4;
  assign o_BubbleCount = r_count;
endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline stage register of the MIPS core, with an integrated load-use hazard detector. It captures decoded instruction fields, operands and control signals from the decode stage and presents them to the execute stage: the ALU control decoder (funct, opcode, 2-bit ALUOp), the ALU, forwarding and the EX/MEM register. It inserts bubbles on branch flush and load-use hazards, and holds its contents on a global stall from the debug unit.

## Interface
- NBITS, 32, datapath width (operands, immediate, PC+4)
- RBITS, 5, register index / shamt width
- ANBITS, 6, funct/opcode width
- NBITSCONTROL, 2, ALUOp width
- BCBITS, 16, bubble counter width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_Stall  in  1  global hold (debug unit); all state frozen
- i_Flush  in  1  branch/jump taken; next load is a bubble
- i_Valid  in  1  ID stage holds a real instruction
- i_Funct, i_Opcode  in  ANBITS each  instruction fields
- i_ALUOp  in  NBITSCONTROL  main-decoder ALU class
- i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst  in  1 each  control
- i_Rs, i_Rt, i_Rd, i_Shamt  in  RBITS each
- i_Data1, i_Data2, i_Imm, i_PC4  in  NBITS each
- o_* (one per i_* above except i_Stall/i_Flush)  out  same widths  registered copies; o_Valid included
- o_Stall_IFID  out  1  combinational load-use stall request to PC and IF/ID
- o_BubbleCount  out  BCBITS  saturating count of inserted bubbles

## Operation
- Hazard: haz = o_Valid & o_MemRead & (o_Rt != 0) & i_Valid & (o_Rt == i_Rs | o_Rt == i_Rt). o_Stall_IFID = haz & ~i_Stall.
- Per-edge priority, highest first:
  - ~i_rst_n: all outputs 0, o_BubbleCount 0.
  - i_Stall: all registers hold; counter holds.
  - i_Flush: bubble load; counter +1.
  - haz: bubble load; counter +1.
  - otherwise: load all i_* fields (o_Valid <= i_Valid); counter holds.
- Bubble load: every o_* field 0, including o_Valid, control, ALUOp (=00, add) and data. Bubbles are deterministic and never write state.
- o_BubbleCount saturates at 2^BCBITS-1; no wrap.
- i_Flush with haz: one bubble, one count.
- A bubble already in ID/EX (o_Valid=0) never raises haz.

## Timing
- Latency 1 cycle: fields present at ID before edge N appear on o_* after edge N.
- Load-use: load in EX at cycle N with a dependent instruction in ID gives o_Stall_IFID=1 during N. At edge N, ID/EX takes a bubble while IF/ID holds. In N+1 haz=0 (bubble), so the dependent instruction loads at edge N+1. Exactly one bubble.
- o_Stall_IFID is purely combinational from o_* and i_Rs/i_Rt/i_Valid; no register on that path.
- Reset mid-stream: synchronous, wins over stall and flush. Outputs 0 after the first edge with i_rst_n=0.

## Structure
- Shared package/header: BUBBLE control constants, ALUOp class encodings (00 add, 01 sub, 10 R-type, 11 immediate), width defaults, register-zero index.
- Sub-module: hazard_detect (combinational haz/o_Stall_IFID). The rest is a single register process plus the counter.

## Test plan
- Reset: i_rst_n=0 for 2 cycles with nonzero inputs -> all o_* 0, o_BubbleCount 0, o_Stall_IFID 0.
- Pass-through: i_Funct=100010, i_ALUOp=10, i_Data1=0x0000_0005, i_Valid=1 -> same values on o_* one edge later, o_Valid=1.
- Load-use: EX holds lw (o_MemRead=1, o_Rt=8); ID has i_Rs=8 -> o_Stall_IFID=1 that cycle; next edge o_Valid=0 and all control 0; count=1. Following edge loads the dependent instruction. Same case with o_Rt=0 -> no stall.
- Flush vs hazard: i_Flush=1 with haz=1 -> single bubble, count increments by exactly 1.
- Stall: i_Stall=1 for 3 cycles with changing inputs and i_Flush=1 -> o_* and count unchanged, o_Stall_IFID=0. Release -> flush bubble applied.
- Saturation (BCBITS=4): 20 consecutive flushes -> count stops at 15.
